// File: rtl/alu16_if.sv
// Request/response bundle for the 16-bit execute-stage ALU.
// The requester drives the operands and the op code; the ALU returns the registered result and flags.
interface alu16_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ctl;
  logic [WIDTH-1:0] y;
  logic             z;
  logic             n;
  logic             c;
  logic             v;
  logic             valid;

  modport master (
    output en, a, b, ctl,
    input  y, z, n, c, v, valid
  );

  modport slave (
    input  en, a, b, ctl,
    output y, z, n, c, v, valid
  );
endinterface

// File: rtl/alu16.sv
// Registered integer ALU: the result and the z/n/c/v flags are captured one clock after an en=1 request.
// The datapath ahead of the output register is purely combinational and holds no state.
module alu16 #(
  parameter int WIDTH = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  alu16_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_NAND = 4'd11;
  localparam logic [3:0] OP_PASA = 4'd12;
  localparam logic [3:0] OP_PASB = 4'd13;
  localparam logic [3:0] OP_ROL  = 4'd14;

  logic [SHW-1:0]     w_sh;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic               w_add_v;
  logic               w_sub_v;
  logic               w_slt;
  logic               w_sltu;
  logic [WIDTH-1:0]   w_sra;
  logic [2*WIDTH-1:0] w_rol2;
  logic [WIDTH-1:0]   w_y;
  logic               w_c;
  logic               w_v;

  logic [WIDTH-1:0]   r_y;
  logic               r_z;
  logic               r_n;
  logic               r_c;
  logic               r_v;
  logic               r_valid;

  assign w_sh  = bus.b[SHW-1:0];
  assign w_add = {1'b0, bus.a} + {1'b0, bus.b};
  // Subtraction as a + ~b + 1 so that bit WIDTH is the no-borrow carry (1 when a >= b unsigned).
  assign w_sub = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};

  assign w_add_v = (bus.a[MSB] == bus.b[MSB]) && (w_add[MSB] != bus.a[MSB]);
  assign w_sub_v = (bus.a[MSB] != bus.b[MSB]) && (w_sub[MSB] != bus.a[MSB]);

  // n XOR v of the difference stays correct even when a - b overflows.
  assign w_slt  = w_sub[MSB] ^ w_sub_v;
  assign w_sltu = ~w_sub[WIDTH];

  assign w_sra  = $unsigned($signed(bus.a) >>> w_sh);
  assign w_rol2 = {bus.a, bus.a} << w_sh;

  always_comb begin
    w_y = '0;
    w_c = 1'b0;
    w_v = 1'b0;
    case (bus.ctl)
      OP_AND:  w_y = bus.a & bus.b;
      OP_OR:   w_y = bus.a | bus.b;
      OP_ADD: begin
        w_y = w_add[MSB:0];
        w_c = w_add[WIDTH];
        w_v = w_add_v;
      end
      OP_XOR:  w_y = bus.a ^ bus.b;
      OP_NOR:  w_y = ~(bus.a | bus.b);
      OP_SLL:  w_y = bus.a << w_sh;
      OP_SUB: begin
        w_y = w_sub[MSB:0];
        w_c = w_sub[WIDTH];
        w_v = w_sub_v;
      end
      OP_SLT:  w_y = {{(WIDTH-1){1'b0}}, w_slt};
      OP_SRL:  w_y = bus.a >> w_sh;
      OP_SRA:  w_y = w_sra;
      OP_SLTU: w_y = {{(WIDTH-1){1'b0}}, w_sltu};
      OP_NAND: w_y = ~(bus.a & bus.b);
      OP_PASA: w_y = bus.a;
      OP_PASB: w_y = bus.b;
      OP_ROL:  w_y = w_rol2[2*WIDTH-1:WIDTH];
      default: w_y = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_z     <= 1'b1;
      r_n     <= 1'b0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
      r_valid <= 1'b0;
    end else if (bus.en) begin
      r_y     <= w_y;
      r_z     <= (w_y == '0);
      r_n     <= w_y[MSB];
      r_c     <= w_c;
      r_v     <= w_v;
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign bus.y     = r_y;
  assign bus.z     = r_z;
  assign bus.n     = r_n;
  assign bus.c     = r_c;
  assign bus.v     = r_v;
  assign bus.valid = r_valid;
endmodule

// File: tb/tb_alu16.sv
// Scoreboard bench for alu16: expected results are queued when a request is driven
// and popped when the registered output appears one clock later.
module tb_alu16;
  typedef struct packed {
    logic [15:0] y;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } exp_t;

  logic clk;
  logic rst_n;
  alu16_if bus ();

  alu16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t sb_q[$];
  exp_t last_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Independent reference: arithmetic flags come from integer range checks and unsigned compares.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    exp_t        r;
    int          sa;
    int          sb;
    int          s;
    logic [3:0]  sh;
    logic [15:0] t;
    r  = '0;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = b[3:0];
    case (op)
      4'd0:  r.y = a & b;
      4'd1:  r.y = a | b;
      4'd2: begin
        r.y = a + b;
        r.c = ((32'(a) + 32'(b)) > 32'h0000FFFF);
        s   = sa + sb;
        r.v = (s > 32767) || (s < -32768);
      end
      4'd3:  r.y = a ^ b;
      4'd4:  r.y = ~(a | b);
      4'd5:  r.y = a << sh;
      4'd6: begin
        r.y = a - b;
        r.c = (a >= b);
        s   = sa - sb;
        r.v = (s > 32767) || (s < -32768);
      end
      4'd7:  r.y = (sa < sb) ? 16'd1 : 16'd0;
      4'd8:  r.y = a >> sh;
      4'd9:  r.y = 16'($signed(a) >>> sh);
      4'd10: r.y = (a < b) ? 16'd1 : 16'd0;
      4'd11: r.y = ~(a & b);
      4'd12: r.y = a;
      4'd13: r.y = b;
      4'd14: begin
        t = a;
        for (int i = 0; i < int'(sh); i++) t = {t[14:0], t[15]};
        r.y = t;
      end
      default: r.y = 16'h0000;
    endcase
    r.z = (r.y == 16'h0000);
    r.n = r.y[15];
    return r;
  endfunction

  task automatic check_outputs(input exp_t ex);
    check_val("y", 32'(bus.y), 32'(ex.y));
    check_val("z", 32'(bus.z), 32'(ex.z));
    check_val("n", 32'(bus.n), 32'(ex.n));
    check_val("c", 32'(bus.c), 32'(ex.c));
    check_val("v", 32'(bus.v), 32'(ex.v));
  endtask

  // One transaction per call: drive at the falling edge, compare just after the next rising edge.
  task automatic issue(input logic e, input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    exp_t ex;
    @(negedge clk);
    bus.en  = e;
    bus.a   = a;
    bus.b   = b;
    bus.ctl = op;
    if (e) sb_q.push_back(model(a, b, op));
    @(posedge clk);
    #1;
    check_val("valid", 32'(bus.valid), 32'(e));
    if (e) begin
      if (sb_q.size() == 0) begin
        check_val("sb_empty", 32'd0, 32'd1);
        ex = last_exp;
      end else begin
        ex = sb_q.pop_front();
      end
      last_exp = ex;
    end else begin
      ex = last_exp;
    end
    check_outputs(ex);
    $display("txn en=%0d ctl=%0d a=%h b=%h -> y=%h z=%0d n=%0d c=%0d v=%0d valid=%0d",
             e, op, a, b, bus.y, bus.z, bus.n, bus.c, bus.v, bus.valid);
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.en   = 1'b0;
    bus.a    = '0;
    bus.b    = '0;
    bus.ctl  = '0;
    last_exp = '{y: 16'h0000, z: 1'b1, n: 1'b0, c: 1'b0, v: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_valid", 32'(bus.valid), 32'd0);
    check_outputs(last_exp);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic logic/arith with equal operands
    issue(1'b1, 16'd25, 16'd25, 4'd0);
    issue(1'b1, 16'd25, 16'd25, 4'd1);
    issue(1'b1, 16'd25, 16'd25, 4'd2);
    issue(1'b1, 16'd25, 16'd25, 4'd3);
    issue(1'b1, 16'd25, 16'd25, 4'd6);
    issue(1'b1, 16'd25, 16'd25, 4'd4);
    issue(1'b1, 16'd25, 16'd25, 4'd5);

    // Negative operand
    issue(1'b1, 16'hFFF6, 16'd25, 4'd6);
    issue(1'b1, 16'hFFF6, 16'd25, 4'd7);
    issue(1'b1, 16'hFFF6, 16'd25, 4'd10);
    issue(1'b1, 16'hFFF6, 16'd25, 4'd8);
    issue(1'b1, 16'hFFF6, 16'd25, 4'd9);

    // Overflow corners
    issue(1'b1, 16'h7FFF, 16'h0001, 4'd2);
    issue(1'b1, 16'h8000, 16'h0001, 4'd6);
    issue(1'b1, 16'h8000, 16'h7FFF, 4'd7);
    issue(1'b1, 16'h7FFF, 16'h8000, 4'd7);
    issue(1'b1, 16'hFFFF, 16'h0001, 4'd2);

    // Shift by zero, upper shift bits ignored, rotate, pass, nand, reserved
    issue(1'b1, 16'hA5C3, 16'hFFF0, 4'd5);
    issue(1'b1, 16'hA5C3, 16'h0010, 4'd8);
    issue(1'b1, 16'h8001, 16'h00F4, 4'd9);
    issue(1'b1, 16'h8001, 16'h0001, 4'd14);
    issue(1'b1, 16'h1234, 16'h0000, 4'd14);
    issue(1'b1, 16'h1234, 16'h5678, 4'd12);
    issue(1'b1, 16'h1234, 16'h5678, 4'd13);
    issue(1'b1, 16'hFFFF, 16'hFFFF, 4'd11);
    issue(1'b1, 16'h1234, 16'h5678, 4'd15);

    // Hold: ADD then three idle cycles with changing inputs
    issue(1'b1, 16'h0100, 16'h0023, 4'd2);
    issue(1'b0, 16'hFFFF, 16'h0001, 4'd6);
    issue(1'b0, 16'h0000, 16'h0000, 4'd15);
    issue(1'b0, 16'h8000, 16'h8000, 4'd2);

    // Back-to-back random requests
    for (int i = 0; i < 40; i++) begin
      issue(1'b1, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
    end

    // Asynchronous reset landing between edges while a request is pending
    issue(1'b1, 16'd1, 16'd2, 4'd2);
    @(negedge clk);
    bus.en  = 1'b1;
    bus.a   = 16'd5;
    bus.b   = 16'd6;
    bus.ctl = 4'd2;
    #2;
    rst_n = 1'b0;
    #1;
    last_exp = '{y: 16'h0000, z: 1'b1, n: 1'b0, c: 1'b0, v: 1'b0};
    check_val("async_rst_valid", 32'(bus.valid), 32'd0);
    check_outputs(last_exp);
    $display("txn async reset mid-request -> y=%h z=%0d valid=%0d", bus.y, bus.z, bus.valid);
    @(posedge clk);
    #1;
    check_val("rst_hold_valid", 32'(bus.valid), 32'd0);
    check_outputs(last_exp);
    sb_q.delete();
    @(negedge clk);
    rst_n  = 1'b1;
    bus.en = 1'b0;

    issue(1'b1, 16'd5, 16'd6, 4'd2);
    issue(1'b1, 16'h8000, 16'h0001, 4'd6);

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
